// File: rtl/nlprg_8_pkg.sv
// Shared constants and step function for the 8-bit non-linear pseudo-random generator.
// The step function is the de Bruijn-modified Fibonacci LFSR update.
package prg_pkg;

  localparam int          PRG8_W    = 8;
  localparam logic [7:0]  PRG8_TAPS = 8'b1011_1000;  // x^8+x^6+x^5+x^4+1
  localparam logic [7:0]  PRG8_RST  = 8'h00;

  // The z term splices 0x00 into the 255-state cycle: 0x80 -> 0x00 -> 0x01.
  function automatic logic [PRG8_W-1:0] prg8_step(input logic [PRG8_W-1:0] s);
    logic lin;
    logic z;
    lin = ^(s & PRG8_TAPS);
    z   = (s[PRG8_W-2:0] == '0);
    return {s[PRG8_W-2:0], lin ^ z};
  endfunction

endpackage

// File: rtl/nlprg_8_fb.sv
// Combinational feedback for the 8-bit generator: current state in, next state out.
module nlfsr_fb
  import prg_pkg::*;
(
  input  logic [PRG8_W-1:0] state_i,
  output logic [PRG8_W-1:0] next_o
);

  always_comb begin
    next_o = prg8_step(state_i);
  end

endmodule

// File: rtl/nlprg_8.sv
// 8-bit non-linear pseudo-random generator with period 256, including 0x00.
// Free-running; the output is the state register itself.
module nlprg_8
  import prg_pkg::*;
#(
  parameter int N = PRG8_W
) (
  input  logic         ck,
  input  logic         rst,
  output logic [N-1:0] o
);

  logic [N-1:0] state_q;
  logic [N-1:0] state_d;

  nlfsr_fb u_fb (
    .state_i (state_q),
    .next_o  (state_d)
  );

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      state_q <= PRG8_RST;
    end else begin
      state_q <= state_d;
    end
  end

  assign o = state_q;

endmodule

// File: tb/tb_nlprg_8.sv
// Self-checking bench for nlprg_8: reset, prefix, splice, full period, mid-run reset, long run.
module tb_nlprg_8;

  logic       ck;
  logic       rst;
  logic [7:0] o;

  int tests_run;
  int tests_failed;

  logic [7:0] model;
  logic [7:0] cnt;
  int         seen [256];
  logic [7:0] period [256];

  nlprg_8 dut (
    .ck  (ck),
    .rst (rst),
    .o   (o)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  // Reference step computed from the rule text: count taps 7,5,4,3, add one
  // when the low seven bits are all zero, take parity, shift in.
  function automatic logic [7:0] ref_next(input logic [7:0] s);
    int ones;
    int fb;
    int taps [4] = '{7, 5, 4, 3};
    ones = 0;
    foreach (taps[t]) ones += int'(s[taps[t]]);
    if ((int'(s) % 128) == 0) ones += 1;
    fb = ones % 2;
    return 8'(((int'(s) * 2) % 256) + fb);
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then sample clear of the edge.
  task automatic step();
    @(posedge ck);
    #1;
    model = ref_next(model);
    cnt   = cnt + 8'd1;
  endtask

  task automatic apply_reset();
    @(negedge ck);
    rst = 1'b0;
    #1;
    model = 8'h00;
    cnt   = 8'h00;
  endtask

  task automatic release_reset();
    @(negedge ck);
    rst = 1'b1;
  endtask

  initial begin
    logic [7:0] prefix [9];
    int         k;
    int         zero_hits;
    int         dup_or_missing;
    tests_run    = 0;
    tests_failed = 0;
    model        = 8'h00;
    cnt          = 8'h00;
    prefix = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47, 8'h8E, 8'h1C};

    // Reset held across clock edges.
    rst = 1'b0;
    #2;
    check("reset_initial", o, 8'h00);
    for (int i = 0; i < 3; i++) begin
      @(posedge ck);
      #1;
      check("reset_hold", o, 8'h00);
    end

    // Prefix after release, against both the literal list and the model.
    release_reset();
    for (int i = 0; i < 9; i++) begin
      step();
      check($sformatf("prefix[%0d]", i), o, prefix[i]);
      check($sformatf("prefix_model[%0d]", i), o, model);
    end

    // Full period from a fresh reset, tracking a wrap counter and value histogram.
    apply_reset();
    check("reset_async", o, 8'h00);
    release_reset();
    foreach (seen[i]) seen[i] = 0;
    zero_hits = 0;
    for (int i = 1; i <= 256; i++) begin
      logic [7:0] prev;
      prev = o;
      step();
      check("period_model", o, model);
      seen[o]++;
      period[i % 256] = o;
      if (prev == 8'h80) check("splice_80_to_00", o, 8'h00);
      if (prev == 8'h00) check("splice_00_to_01", o, 8'h01);
      if (o == 8'h00) begin
        zero_hits++;
        check("zero_at_wrap", cnt, 8'h00);
      end
    end
    check("zero_once_per_period", 8'(zero_hits), 8'd1);
    check("period_end_zero", o, 8'h00);
    dup_or_missing = 0;
    foreach (seen[v]) if (seen[v] != 1) dup_or_missing++;
    check("all_values_once", 8'(dup_or_missing), 8'd0);

    // Long run: three further periods must match the recorded one.
    for (int i = 1; i <= 768; i++) begin
      step();
      check("long_run_repeat", o, period[i % 256]);
      if (o == 8'h00) check("long_zero_at_wrap", cnt, 8'h00);
    end

    // Mid-run resets at random steps, asserted between edges.
    for (int r = 0; r < 4; r++) begin
      k = int'($urandom_range(1, 300));
      for (int i = 0; i < k; i++) step();
      check("midrun_pre", o, model);
      @(posedge ck);
      #3;
      rst = 1'b0;
      #1;
      check("midrun_async_clear", o, 8'h00);
      model = 8'h00;
      cnt   = 8'h00;
      repeat (int'($urandom_range(0, 3))) begin
        @(posedge ck);
        #1;
        check("midrun_hold", o, 8'h00);
      end
      release_reset();
      for (int i = 0; i < 3; i++) begin
        step();
        check($sformatf("midrun_restart[%0d]", i), o, prefix[i]);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
